// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - two-requester arbiter feeding a registered bitwise AND/OR/NOT unit
// Optional macro LOGIC_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module logic_op_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] Y,
  output logic             valid,
  input  logic             ready,
  output logic             id,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sel;
  logic             sel_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] y_nxt;
  logic             err_nxt;
  logic             take;

  // A grant is only ever issued from IDLE; requests in EXEC/DONE are ignored.
  assign take = (state == IDLE) && (req != 2'b00);

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
  logic ptr;

  always_comb begin
    sel = 1'b0;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ptr;
      default: sel = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (take) begin
      ptr <= ~sel;
    end
  end
`else
  // Requester 0 always wins; requester 1 only when 0 is idle.
  assign sel = ~req[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req != 2'b00) state_nxt = EXEC;
      end
      EXEC:    state_nxt = DONE;
      DONE:    if (ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    y_nxt   = '0;
    err_nxt = 1'b0;
    case (op_r)
      2'b00:   y_nxt = a_r & b_r;
      2'b01:   y_nxt = a_r | b_r;
      2'b10:   y_nxt = ~a_r;
      default: err_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt   <= 2'b00;
      sel_r <= 1'b0;
      op_r  <= 2'b00;
      a_r   <= '0;
      b_r   <= '0;
      Y     <= '0;
      valid <= 1'b0;
      id    <= 1'b0;
      err   <= 1'b0;
    end else begin
      gnt <= 2'b00;
      if (take) begin
        gnt   <= sel ? 2'b10 : 2'b01;
        sel_r <= sel;
        op_r  <= sel ? op1 : op0;
        a_r   <= sel ? A1 : A0;
        b_r   <= sel ? B1 : B0;
      end
      if (state == EXEC) begin
        Y     <= y_nxt;
        id    <= sel_r;
        err   <= err_nxt;
        valid <= 1'b1;
      end
      // Y and id are left as-is so the last result stays observable.
      if (state == DONE && ready) begin
        valid <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

endmodule
